peri_bus_arbiter: RTL and testbench
===================================

// Module: peri_bus_arbiter
// PURPOSE
//  Two-master arbiter for the 8-bit peripheral bus (RAM 0x00-0x7F, SPI 0x80-0x83, GPIO 0x84-0x87).
//  Shares that bus between master 0 (the CPU) and master 1 (a DMA/bridge engine).
//  Uses round-robin fairness, optional bus lock for multi-beat sequences, and a hold limit against starvation.
//  Sits between the masters and the existing address decode / peri_din mux.
// PARAMETERS
//  ADDR_WIDTH  8  width of the bus address
//  DATA_WIDTH  8  width of read and write data
//  MAX_HOLD    8  max consecutive locked beats while the other master waits; 0 = unlimited
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  reset      in   1   synchronous reset, active-high
//  m0_req     in   1   master 0 requests a beat
//  m0_lock    in   1   master 0 keeps ownership after the current beat
//  m0_we      in   1   1 = write beat, 0 = read beat
//  m0_addr    in   AW  beat address
//  m0_wdata   in   DW  write data
//  m0_gnt     out  1   master 0 owns the bus
//  m0_ack     out  1   beat completed (1-cycle pulse)
//  m0_rdata   out  DW  read data; valid when m0_ack=1, held until the next ack
//  m1_*       --   --  identical set for master 1
//  bus_addr   out  AW  to the peripheral decode
//  bus_wdata  out  DW  to the peripheral decode
//  bus_wr_en  out  1   to the peripheral decode
//  bus_rd_en  out  1   to the peripheral decode
//  bus_rdata  in   DW  combinational read data from the peripheral mux
//  owner      out  2   00 none, 01 m0, 10 m1
// BEHAVIOUR
//  Reset
//  - All outputs 0.
//  - State IDLE, last_owner=m1 (m0 wins the first tie), hold_cnt=0.
//  - Reset during a beat aborts it; no ack is issued.
//  State machine: IDLE, OWN0, OWN1
//  - mX_gnt=1 exactly in OWNX; owner mirrors the state.
//  - Arbitration is evaluated at each edge in IDLE, and at the end of every beat or idle-owner cycle.
//    - One requester: that master wins.
//    - Both request: the master that is not last_owner wins.
//  - Grant latency: req seen in IDLE -> gnt high on the next cycle.
//    Masters hold req/we/addr/wdata stable until gnt is seen.
//  Beats
//  - A beat is any cycle with mX_gnt=1 and mX_req=1.
//  - The bus is driven combinationally from the owner:
//    - bus_addr = mX_addr, bus_wdata = mX_wdata
//    - bus_wr_en = req & we, bus_rd_en = req & ~we
//  - With no owner, or owner req=0: bus_* = 0.
//  - At the beat's edge: mX_rdata <= bus_rdata (reads only; writes leave rdata unchanged).
//    mX_ack is 1 for the following cycle.
//  - Back-to-back beats by one owner: one beat per cycle, no bubbles.
//  End of beat, lock=0
//  - Re-arbitrate with the just-served master at lowest priority.
//  - Other master requesting: switch directly OWNX->OWNY (no IDLE cycle).
//  - Otherwise stay OWNX if mX_req remains high, else go to IDLE.
//  End of beat, lock=1
//  - Stay OWNX.
//  - hold_cnt increments when the other master is requesting.
//  - When hold_cnt reaches MAX_HOLD (MAX_HOLD!=0): forced handover to the other master. hold_cnt clears.
//  Other ownership rules
//  - Owner with req=0 in OWNX:
//    - Released at that edge regardless of lock.
//    - Goes to the other master if it is requesting, else to IDLE.
//  - hold_cnt clears on any change of ownership or when the other master is not requesting.
//    Width: clog2(MAX_HOLD+1), saturating.
//  - last_owner updates whenever a grant is made.
//  - Simultaneous new requests in IDLE: resolved by the round-robin rule only. No combinational req->gnt path.
// TESTING
//  1. Reset, m0 read 0x05 with bus_rdata=0x3C.
//     -> gnt cycle 1, bus_rd_en cycle 1, m0_ack+m0_rdata=0x3C cycle 2.
//  2. m0 and m1 both request from IDLE after reset.
//     -> m0 granted first, m1 next beat, then alternate (m0,m1,m0,m1), no idle cycles.
//  3. m1 writes 0x84<=0xA5 while m0 idle.
//     -> bus_wr_en=1, bus_addr=0x84, bus_wdata=0xA5 for 1 cycle; m1_ack next; m1_rdata unchanged.
//  4. m0 lock=1 for 20 beats, m1 requesting, MAX_HOLD=8.
//     -> m1 granted after m0's 8th beat; m0 regains the bus after m1's beat.
//  5. Same as 4 with MAX_HOLD=0.
//     -> m1 waits until m0 drops lock; no beat lost or duplicated.
//  6. reset asserted during an m1 write beat.
//     -> next cycle all outputs 0, no ack, owner=00, then m0 wins the first tie.

Source files
------------

// File: rtl/peri_bus_arbiter.sv
// Two-master arbiter for the 8-bit peripheral bus. It provides round-robin
// fairness between master 0 (CPU) and master 1 (DMA/bridge). An owner can lock
// the bus for multi-beat sequences. A hold limit stops one master from
// starving the other.
module peri_bus_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_wr_en,
  output logic                  bus_rd_en,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [1:0]            owner
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          state, state_nxt, other_state;
  logic            last_owner, last_nxt;   // 1 = master 1 was granted last
  logic [HW-1:0]   hold_cnt, hold_nxt, hold_inc;
  logic            own_req, own_lock, oth_req, hold_limit;
  logic            beat0, beat1;

  assign beat0  = (state == OWN0) && m0_req;
  assign beat1  = (state == OWN1) && m1_req;
  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);
  assign owner  = {state == OWN1, state == OWN0};

  // Owner-relative view, so that OWN0 and OWN1 can share one set of rules
  always_comb begin
    own_req     = 1'b0;
    own_lock    = 1'b0;
    oth_req     = 1'b0;
    other_state = IDLE;
    if (state == OWN0) begin
      own_req     = m0_req;
      own_lock    = m0_lock;
      oth_req     = m1_req;
      other_state = OWN1;
    end else if (state == OWN1) begin
      own_req     = m1_req;
      own_lock    = m1_lock;
      oth_req     = m0_req;
      other_state = OWN0;
    end
  end

  assign hold_inc   = (hold_cnt == '1) ? hold_cnt : hold_cnt + HW'(1);
  assign hold_limit = (MAX_HOLD != 0) && ((int'(hold_cnt) + 1) >= MAX_HOLD);

  // Next ownership, hold count and round-robin pointer
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    last_nxt  = last_owner;
    if (state == IDLE) begin
      if (m0_req && m1_req) state_nxt = last_owner ? OWN0 : OWN1;
      else if (m0_req)      state_nxt = OWN0;
      else if (m1_req)      state_nxt = OWN1;
    end else if (!own_req) begin
      state_nxt = oth_req ? other_state : IDLE;
    end else if (!own_lock) begin
      state_nxt = oth_req ? other_state : state;
    end else if (oth_req) begin
      if (hold_limit) state_nxt = other_state;
      else            hold_nxt  = hold_inc;
    end
    if (state_nxt == OWN0)      last_nxt = 1'b0;
    else if (state_nxt == OWN1) last_nxt = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      hold_cnt   <= hold_nxt;
    end
  end

  // Route the owning master onto the bus while it requests
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
    if (beat0) begin
      bus_addr  = m0_addr;
      bus_wdata = m0_wdata;
      bus_wr_en = m0_we;
      bus_rd_en = ~m0_we;
    end else if (beat1) begin
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
      bus_wr_en = m1_we;
      bus_rd_en = ~m1_we;
    end
  end

  // Beat completion: one-cycle ack pulse, and read data captured at the beat edge
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= beat0;
      m1_ack <= beat1;
      if (beat0 && !m0_we) m0_rdata <= bus_rdata;
      if (beat1 && !m1_we) m1_rdata <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Self-checking bench for peri_bus_arbiter. Two instances share all inputs:
// dut_a uses MAX_HOLD=8 and dut_b uses MAX_HOLD=0 (unlimited lock).
module tb_peri_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

  logic       a_m0_gnt, a_m0_ack, a_m1_gnt, a_m1_ack, a_wr, a_rd;
  logic [7:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata;
  logic [1:0] a_owner;
  logic       b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack, b_wr, b_rd;
  logic [7:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata;
  logic [1:0] b_owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  peri_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(8)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .bus_addr(a_addr), .bus_wdata(a_wdata), .bus_wr_en(a_wr), .bus_rd_en(a_rd),
    .bus_rdata(bus_rdata), .owner(a_owner)
  );

  peri_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(0)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_wr_en(b_wr), .bus_rd_en(b_rd),
    .bus_rdata(bus_rdata), .owner(b_owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    checks++;
    if ({a_m0_gnt, a_m1_gnt, a_m0_ack, a_m1_ack, a_owner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {a_m0_gnt, a_m1_gnt, a_m0_ack, a_m1_ack, a_owner});
    end
    checks++;
    if ({a_addr, a_wdata, a_wr, a_rd, a_m0_rdata, a_m1_rdata} !== 34'b0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0", {a_addr, a_wdata, a_wr, a_rd, a_m0_rdata, a_m1_rdata});
    end
    reset = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 8'h05; bus_rdata = 8'h3C;
    #1;
    checks++;
    if (a_m0_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_c0: got %b want 0", a_m0_gnt); end
    tick();
    checks++;
    if ({a_m0_gnt, a_owner, a_rd, a_wr, a_addr, a_m0_ack} !== {1'b1, 2'b01, 1'b1, 1'b0, 8'h05, 1'b0}) begin
      errors++;
      $display("FAIL rd_c1: got %b want %b", {a_m0_gnt, a_owner, a_rd, a_wr, a_addr, a_m0_ack},
               {1'b1, 2'b01, 1'b1, 1'b0, 8'h05, 1'b0});
    end
    tick();
    m0_req = 0;
    #1;
    checks++;
    if ({a_m0_ack, a_m0_rdata, a_rd} !== {1'b1, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL rd_c2: got ack=%b rdata=%h rd=%b want ack=1 rdata=3c rd=0", a_m0_ack, a_m0_rdata, a_rd);
    end
    tick();
    checks++;
    if ({a_m0_ack, a_m0_gnt, a_owner} !== 4'b0) begin
      errors++;
      $display("FAIL rd_c3_idle: got %b want 0000", {a_m0_ack, a_m0_gnt, a_owner});
    end
  endtask

  task automatic test_rr_alternate();
    logic [1:0] want;
    do_reset();
    m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      want = (c % 2 == 1) ? 2'b01 : 2'b10;
      checks++;
      if (a_owner !== want) begin
        errors++;
        $display("FAIL rr_owner_c%0d: got %b want %b", c, a_owner, want);
      end
    end
    m0_req = 0; m1_req = 0;
    tick();
  endtask

  task automatic test_write();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 8'h84; m1_wdata = 8'hA5; bus_rdata = 8'h5A;
    tick();
    checks++;
    if ({a_m1_gnt, a_owner, a_wr, a_rd, a_addr, a_wdata} !== {1'b1, 2'b10, 1'b1, 1'b0, 8'h84, 8'hA5}) begin
      errors++;
      $display("FAIL wr_c1: got %h want %h", {a_m1_gnt, a_owner, a_wr, a_rd, a_addr, a_wdata},
               {1'b1, 2'b10, 1'b1, 1'b0, 8'h84, 8'hA5});
    end
    tick();
    m1_req = 0;
    #1;
    checks++;
    if ({a_m1_ack, a_m1_rdata, a_wr, a_m0_ack} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr_c2: got ack=%b rdata=%h wr=%b m0_ack=%b want 1 00 0 0", a_m1_ack, a_m1_rdata, a_wr, a_m0_ack);
    end
    tick();
  endtask

  task automatic test_hold_limit();
    logic [1:0] want_a;
    int acks_b = 0;
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1; m1_lock = 0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c <= 20) begin
        want_a = (((c - 1) % 9) == 8) ? 2'b10 : 2'b01;
        checks++;
        if (a_owner !== want_a) begin
          errors++;
          $display("FAIL hold8_owner_c%0d: got %b want %b", c, a_owner, want_a);
        end
      end
      if (c <= 21) begin
        checks++;
        if (b_owner !== 2'b01) begin
          errors++;
          $display("FAIL hold0_owner_c%0d: got %b want 01", c, b_owner);
        end
      end
      if (c >= 2) acks_b += int'(b_m0_ack);
      if (c == 21) m0_lock = 0;
    end
    checks++;
    if (b_owner !== 2'b10) begin errors++; $display("FAIL hold0_release: got %b want 10", b_owner); end
    checks++;
    if (acks_b != 21) begin errors++; $display("FAIL hold0_beats: got %0d want 21", acks_b); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_beat();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 8'h86; m1_wdata = 8'h11;
    tick();
    checks++;
    if ({a_owner, a_wr} !== 3'b101) begin errors++; $display("FAIL rstbeat_c1: got %b want 101", {a_owner, a_wr}); end
    reset = 1;
    m0_req = 1;
    tick();
    checks++;
    if ({a_m0_gnt, a_m1_gnt, a_m0_ack, a_m1_ack, a_owner, a_wr, a_rd, a_addr, a_wdata} !== 24'b0) begin
      errors++;
      $display("FAIL rstbeat_c2: got %h want 0",
               {a_m0_gnt, a_m1_gnt, a_m0_ack, a_m1_ack, a_owner, a_wr, a_rd, a_addr, a_wdata});
    end
    reset = 0;
    tick();
    checks++;
    if ({a_owner, a_m1_ack} !== 3'b010) begin errors++; $display("FAIL rstbeat_tie: got %b want 010", {a_owner, a_m1_ack}); end
    idle_inputs();
    tick();
  endtask

  // Reference model: owner as 0/1/2 (none/m0/m1), integer hold counts
  int         own[2], last[2], hold[2];
  int         mh[2] = '{8, 0};
  logic       ack_m[2][2];
  logic [7:0] rd_m[2][2];

  task automatic model_edge();
    logic       r[2], l[2], w[2];
    int         nw, x, y;
    r = '{m0_req, m1_req}; l = '{m0_lock, m1_lock}; w = '{m0_we, m1_we};
    for (int k = 0; k < 2; k++) begin
      ack_m[k][0] = 0; ack_m[k][1] = 0;
      if (own[k] == 0) begin
        if (r[0] && r[1]) nw = (last[k] == 2) ? 1 : 2;
        else if (r[0])    nw = 1;
        else if (r[1])    nw = 2;
        else              nw = 0;
        hold[k] = 0;
      end else begin
        x = own[k] - 1; y = 1 - x;
        if (!r[x]) begin
          nw = r[y] ? y + 1 : 0; hold[k] = 0;
        end else begin
          ack_m[k][x] = 1;
          if (!w[x]) rd_m[k][x] = bus_rdata;
          if (!l[x]) begin
            nw = r[y] ? y + 1 : own[k]; hold[k] = 0;
          end else if (r[y]) begin
            hold[k]++;
            if (mh[k] != 0 && hold[k] >= mh[k]) begin nw = y + 1; hold[k] = 0; end
            else nw = own[k];
          end else begin
            nw = own[k]; hold[k] = 0;
          end
        end
      end
      if (nw != 0) last[k] = nw;
      own[k] = nw;
    end
  endtask

  task automatic test_random();
    logic [1:0]  g_o, o_o, g_e, o_e;
    logic [17:0] bus_o, bus_e;
    logic [17:0] ar_o, ar_e;
    logic [7:0]  addr_s[2], wd_s[2];
    logic        we_s[2], rq_s[2];
    do_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = 0; last[k] = 2; hold[k] = 0;
      ack_m[k][0] = 0; ack_m[k][1] = 0; rd_m[k][0] = '0; rd_m[k][1] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      m0_req = ($urandom_range(0, 3) != 0); m1_req = ($urandom_range(0, 3) != 0);
      m0_lock = ($urandom_range(0, 9) < 7); m1_lock = ($urandom_range(0, 9) < 7);
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_addr = 8'($urandom); m1_addr = 8'($urandom);
      m0_wdata = 8'($urandom); m1_wdata = 8'($urandom);
      bus_rdata = 8'($urandom);
      addr_s = '{m0_addr, m1_addr}; wd_s = '{m0_wdata, m1_wdata};
      we_s = '{m0_we, m1_we}; rq_s = '{m0_req, m1_req};
      #1;
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin g_o = {a_m1_gnt, a_m0_gnt}; o_o = a_owner; bus_o = {a_addr, a_wdata, a_wr, a_rd}; end
        else        begin g_o = {b_m1_gnt, b_m0_gnt}; o_o = b_owner; bus_o = {b_addr, b_wdata, b_wr, b_rd}; end
        g_e = {own[k] == 2, own[k] == 1};
        o_e = (own[k] == 1) ? 2'b01 : (own[k] == 2) ? 2'b10 : 2'b00;
        bus_e = '0;
        if (own[k] != 0 && rq_s[own[k] - 1])
          bus_e = {addr_s[own[k] - 1], wd_s[own[k] - 1], we_s[own[k] - 1], ~we_s[own[k] - 1]};
        checks++;
        if ({g_o, o_o} !== {g_e, o_e}) begin
          errors++;
          $display("FAIL rand_grant k%0d c%0d: got gnt=%b owner=%b want gnt=%b owner=%b", k, c, g_o, o_o, g_e, o_e);
        end
        checks++;
        if (bus_o !== bus_e) begin
          errors++;
          $display("FAIL rand_bus k%0d c%0d: got %h want %h", k, c, bus_o, bus_e);
        end
      end
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < 2; k++) begin
        if (k == 0) ar_o = {a_m1_ack, a_m0_ack, a_m1_rdata, a_m0_rdata};
        else        ar_o = {b_m1_ack, b_m0_ack, b_m1_rdata, b_m0_rdata};
        ar_e = {ack_m[k][1], ack_m[k][0], rd_m[k][1], rd_m[k][0]};
        checks++;
        if (ar_o !== ar_e) begin
          errors++;
          $display("FAIL rand_ack_rdata k%0d c%0d: got %h want %h", k, c, ar_o, ar_e);
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_rr_alternate();
    test_write();
    test_hold_limit();
    test_reset_mid_beat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
